// File: rtl/accumulator_scheduler_if.sv
// Request lanes and drain stream of the accumulator scheduler.
// Valid/ready: a beat transfers at a rising edge where valid and ready are both high;
// valid never waits on ready, and a raised valid holds, with its payload stable, until the beat transfers.
interface accumulator_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int RW      = 8,
    parameter int DW      = 16,
    parameter int EW      = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*RW-1:0] req_row;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  drain_valid;
    logic [DW-1:0]         drain_data;
    logic [EW-1:0]         drain_entry;
    logic                  drain_ready;

    modport master (
        output req_valid, req_row, req_data, drain_ready,
        input  req_ready, drain_valid, drain_data, drain_entry
    );

    modport slave (
        input  req_valid, req_row, req_data, drain_ready,
        output req_ready, drain_valid, drain_data, drain_entry
    );
endinterface

// File: rtl/accumulator_scheduler.sv
// Round-robin write arbiter and tile sequencer (accumulate, drain, clear) for one accumulator buffer.
module accumulator_scheduler #(
    parameter int NUM_REQ                = 4,
    parameter int TILE_SIZE              = 256,
    parameter int BUFFER_WIDTH           = 8,
    parameter int SMALLEST_ELEMENT_WIDTH = 4,
    localparam int RW = $clog2(TILE_SIZE),
    localparam int DW = 4 * SMALLEST_ELEMENT_WIDTH,
    localparam int EW = $clog2(BUFFER_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tile_start,
    input  logic                  tile_end,
    input  logic [1:0]            bitwidth_in,
    accumulator_scheduler_if.slave bus,
    output logic [RW-1:0]         buffer_row_write,
    output logic [RW-1:0]         buffer_column_write,
    output logic [DW-1:0]         buffer_data_write,
    output logic                  buffer_write_enable,
    output logic [1:0]            bitwidth,
    output logic                  transfer,
    output logic [EW-1:0]         buffer_bank_entry,
    input  logic [DW-1:0]         buffer_data_read,
    output logic                  tile_done,
    output logic                  cfg_error,
    output logic                  busy,
    output logic [2:0]            state_dbg
);
    localparam int LW    = $clog2(NUM_REQ);
    localparam int TOTAL = BUFFER_WIDTH * SMALLEST_ELEMENT_WIDTH;

    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, DRAIN, CLEAR} state_t;

    state_t               state, state_next;
    logic [LW-1:0]        rr_ptr;
    logic [LW-1:0]        probe;
    logic [LW-1:0]        grant_idx;
    logic                 grant_any;
    logic [NUM_REQ-1:0]   grant;
    logic [EW-1:0]        entry;
    logic [31:0]          n_entries;
    logic                 entry_last;
    logic                 start_ok;
    logic                 start_bad;

    assign start_ok   = (state == IDLE) && tile_start && (bitwidth_in != 2'd3);
    assign start_bad  = (state == IDLE) && tile_start && (bitwidth_in == 2'd3);
    assign n_entries  = TOTAL >> (2 + bitwidth);
    assign entry_last = (32'(entry) == n_entries - 32'd1);

    // Search starts at rr_ptr; NUM_REQ is a power of two so the index wraps on its own.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        probe     = '0;
        if (state == ACCUM && !tile_end) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                probe = rr_ptr + k[LW-1:0];
                if (!grant_any && bus.req_valid[probe]) begin
                    grant_any = 1'b1;
                    grant_idx = probe;
                end
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = ACCUM;
            ACCUM:   if (tile_end) state_next = FLUSH;
            FLUSH:   state_next = DRAIN;
            DRAIN:   if (bus.drain_ready && entry_last) state_next = CLEAR;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr              <= '0;
            buffer_row_write    <= '0;
            buffer_column_write <= '0;
            buffer_data_write   <= '0;
            buffer_write_enable <= 1'b0;
            bitwidth            <= 2'd0;
            entry               <= '0;
            cfg_error           <= 1'b0;
        end else begin
            buffer_write_enable <= grant_any;
            cfg_error           <= start_bad;
            if (grant_any) begin
                rr_ptr              <= grant_idx + LW'(1);
                buffer_row_write    <= bus.req_row[grant_idx*RW +: RW];
                buffer_data_write   <= bus.req_data[grant_idx*DW +: DW];
                buffer_column_write <= RW'(grant_idx);
            end
            if (start_ok) begin
                bitwidth <= bitwidth_in;
                entry    <= '0;
            end else if (state == DRAIN && bus.drain_ready) begin
                entry <= entry + EW'(1);
            end
        end
    end

    assign bus.req_ready   = grant;
    assign bus.drain_valid = (state == DRAIN);
    assign bus.drain_entry = entry;
    // Gated so the stream reads zero outside DRAIN, whatever the buffer presents.
    assign bus.drain_data  = (state == DRAIN) ? buffer_data_read : '0;
    assign buffer_bank_entry = entry;
    assign transfer  = (state == CLEAR);
    assign tile_done = (state == CLEAR);
    assign busy      = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_accumulator_scheduler.sv
// Directed bench for accumulator_scheduler with a small saturating accumulator buffer model.
module tb_accumulator_scheduler;
  localparam int NUM_REQ = 4;
  localparam int RW = 8;
  localparam int DW = 16;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tile_start = 1'b0;
  logic tile_end = 1'b0;
  logic [1:0] bitwidth_in = 2'd0;
  logic [RW-1:0] buffer_row_write, buffer_column_write;
  logic [DW-1:0] buffer_data_write, buffer_data_read;
  logic buffer_write_enable, transfer, tile_done, cfg_error, busy;
  logic [1:0] bitwidth;
  logic [EW-1:0] buffer_bank_entry;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[8];

  accumulator_scheduler_if #(.NUM_REQ(NUM_REQ), .RW(RW), .DW(DW), .EW(EW)) bus ();

  accumulator_scheduler dut (
    .clk(clk), .reset_n(reset_n), .tile_start(tile_start), .tile_end(tile_end),
    .bitwidth_in(bitwidth_in), .bus(bus),
    .buffer_row_write(buffer_row_write), .buffer_column_write(buffer_column_write),
    .buffer_data_write(buffer_data_write), .buffer_write_enable(buffer_write_enable),
    .bitwidth(bitwidth), .transfer(transfer), .buffer_bank_entry(buffer_bank_entry),
    .buffer_data_read(buffer_data_read), .tile_done(tile_done), .cfg_error(cfg_error),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // signed saturating add at the tile element width
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] bw);
    int w, lim, sa, sb, s;
    w = 4 << bw;
    lim = 1 << (w - 1);
    sa = int'(a) & ((1 << w) - 1);
    sb = int'(b) & ((1 << w) - 1);
    if (sa >= lim) sa -= 2 * lim;
    if (sb >= lim) sb -= 2 * lim;
    s = sa + sb;
    if (s > lim - 1) s = lim - 1;
    if (s < -lim) s = -lim;
    return DW'(s & ((1 << w) - 1));
  endfunction

  logic [RW-1:0] wr_idx;
  assign wr_idx = buffer_row_write >> bitwidth;
  assign buffer_data_read = mem[buffer_bank_entry];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (transfer) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (buffer_write_enable) begin
      mem[wr_idx[EW-1:0]] <= sat_add(mem[wr_idx[EW-1:0]], buffer_data_write, bitwidth);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [1:0] bw);
    tile_start = 1'b1;
    bitwidth_in = bw;
    cyc();
    tile_start = 1'b0;
    #1;
    total++;
    if (state_dbg !== 3'd1 || bitwidth !== bw) begin
      bad++;
      $display("FAIL start_tile: state=%0d bitwidth=%0d want state=1 bitwidth=%0d", state_dbg, bitwidth, bw);
    end
  endtask

  task automatic set_lane(input int lane, input logic [RW-1:0] row, input logic [DW-1:0] data);
    bus.req_valid[lane] = 1'b1;
    bus.req_row[lane*RW +: RW] = row;
    bus.req_data[lane*DW +: DW] = data;
  endtask

  task automatic end_tile();
    tile_end = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL end_grant: req_ready=%b want 0000", bus.req_ready);
    end
    cyc();
    tile_end = 1'b0;
    bus.req_valid = '0;
    #1;
    total++;
    if (state_dbg !== 3'd2 || buffer_write_enable !== 1'b0) begin
      bad++;
      $display("FAIL flush: state=%0d we=%b want state=2 we=0", state_dbg, buffer_write_enable);
    end
    cyc();
  endtask

  // scoreboard: pops exp_q on every accepted drain beat
  task automatic run_drain(input int n, input bit stall);
    int got = 0;
    int k = 0;
    logic [DW-1:0] want;
    while (got < n && k < 64) begin
      bus.drain_ready = stall ? k[0] : 1'b1;
      #1;
      total++;
      if (bus.drain_valid !== 1'b1 || bus.drain_entry !== EW'(got) || tile_done !== 1'b0) begin
        bad++;
        $display("FAIL drain_ctl: valid=%b entry=%0d done=%b want valid=1 entry=%0d done=0",
                 bus.drain_valid, bus.drain_entry, tile_done, got);
      end
      if (bus.drain_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.drain_data !== want) begin
          bad++;
          $display("FAIL drain_data[%0d]: got %h want %h", got, bus.drain_data, want);
        end
        got++;
      end
      cyc();
      k++;
    end
    bus.drain_ready = 1'b0;
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL drain_timeout: accepted %0d want %0d", got, n);
    end
    #1;
    total++;
    if (transfer !== 1'b1 || tile_done !== 1'b1 || state_dbg !== 3'd4) begin
      bad++;
      $display("FAIL clear: transfer=%b done=%b state=%0d want 1 1 4", transfer, tile_done, state_dbg);
    end
    cyc();
    total++;
    if (busy !== 1'b0 || tile_done !== 1'b0 || transfer !== 1'b0) begin
      bad++;
      $display("FAIL idle_after: busy=%b done=%b transfer=%b want 0 0 0", busy, tile_done, transfer);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (busy !== 1'b0 || buffer_write_enable !== 1'b0 || bus.req_ready !== 4'b0 ||
        bus.drain_valid !== 1'b0 || bus.drain_entry !== 3'd0 || bus.drain_data !== 16'h0 ||
        transfer !== 1'b0 || tile_done !== 1'b0 || cfg_error !== 1'b0 || bitwidth !== 2'd0 ||
        state_dbg !== 3'd0 || buffer_row_write !== 8'h0 || buffer_data_write !== 16'h0) begin
      bad++;
      $display("FAIL %s: busy=%b we=%b rdy=%b dv=%b de=%0d dd=%h tr=%b td=%b ce=%b bw=%0d st=%0d want all 0",
               name, busy, buffer_write_enable, bus.req_ready, bus.drain_valid, bus.drain_entry,
               bus.drain_data, transfer, tile_done, cfg_error, bitwidth, state_dbg);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    cyc();
    cyc();
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_fairness();
    start_tile(2'd0);
    for (int i = 0; i < 4; i++) set_lane(i, RW'(i), 16'h0001);
    for (int j = 0; j < 8; j++) begin
      #1;
      total++;
      if (bus.req_ready !== 4'(1 << (j % 4))) begin
        bad++;
        $display("FAIL rr_grant[%0d]: req_ready=%b want %b", j, bus.req_ready, 4'(1 << (j % 4)));
      end
      total++;
      if (buffer_write_enable !== (j > 0) || (j > 0 && buffer_column_write !== RW'((j - 1) % 4))) begin
        bad++;
        $display("FAIL rr_write[%0d]: we=%b col=%0d want we=%b col=%0d", j, buffer_write_enable,
                 buffer_column_write, j > 0, (j + 3) % 4);
      end
      cyc();
    end
    #1;
    total++;
    if (buffer_write_enable !== 1'b1 || buffer_column_write !== 8'd3 || buffer_row_write !== 8'd3) begin
      bad++;
      $display("FAIL rr_last: we=%b col=%0d row=%0d want 1 3 3", buffer_write_enable, buffer_column_write, buffer_row_write);
    end
    end_tile();
    exp_q = '{16'h2, 16'h2, 16'h2, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0};
    run_drain(8, 1'b0);
  endtask

  task automatic test_accumulate();
    start_tile(2'd2);
    set_lane(1, 8'd0, 16'h0003);
    for (int j = 0; j < 3; j++) begin
      #1;
      total++;
      if (bus.req_ready !== 4'b0010) begin
        bad++;
        $display("FAIL acc_grant[%0d]: req_ready=%b want 0010", j, bus.req_ready);
      end
      cyc();
    end
    bus.req_valid = '0;
    #1;
    total++;
    if (buffer_write_enable !== 1'b1 || buffer_column_write !== 8'd1 || buffer_data_write !== 16'h0003) begin
      bad++;
      $display("FAIL acc_write: we=%b col=%0d data=%h want 1 1 0003", buffer_write_enable, buffer_column_write, buffer_data_write);
    end
    end_tile();
    exp_q = '{16'h0009, 16'h0000};
    run_drain(2, 1'b0);
  endtask

  task automatic test_saturation();
    start_tile(2'd1);
    set_lane(0, 8'd2, 16'h007F);
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL sat_grant: req_ready=%b want 0001", bus.req_ready);
    end
    cyc();
    set_lane(0, 8'd2, 16'h0001);
    cyc();
    bus.req_valid = '0;
    end_tile();
    exp_q = '{16'h0000, 16'h007F, 16'h0000, 16'h0000};
    run_drain(4, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    start_tile(2'd0);
    set_lane(2, 8'd5, 16'h0005);
    cyc();
    bus.req_valid = '0;
    end_tile();
    exp_q = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h5, 16'h0, 16'h0};
    run_drain(8, 1'b1);
  endtask

  task automatic test_illegal_start();
    tile_start = 1'b1;
    bitwidth_in = 2'd3;
    cyc();
    tile_start = 1'b0;
    #1;
    total++;
    if (cfg_error !== 1'b1 || busy !== 1'b0 || bitwidth !== 2'd0) begin
      bad++;
      $display("FAIL cfg_error: err=%b busy=%b bw=%0d want 1 0 0", cfg_error, busy, bitwidth);
    end
    cyc();
    total++;
    if (cfg_error !== 1'b0 || state_dbg !== 3'd0) begin
      bad++;
      $display("FAIL cfg_pulse: err=%b state=%0d want 0 0", cfg_error, state_dbg);
    end
    start_tile(2'd1);
    end_tile();
    tile_start = 1'b1;
    bitwidth_in = 2'd2;
    cyc();
    tile_start = 1'b0;
    #1;
    total++;
    if (state_dbg !== 3'd3 || bitwidth !== 2'd1 || bus.drain_entry !== 3'd0 || cfg_error !== 1'b0) begin
      bad++;
      $display("FAIL start_in_drain: state=%0d bw=%0d entry=%0d err=%b want 3 1 0 0",
               state_dbg, bitwidth, bus.drain_entry, cfg_error);
    end
    exp_q = '{16'h0, 16'h0, 16'h0, 16'h0};
    run_drain(4, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    start_tile(2'd0);
    set_lane(1, 8'd0, 16'h0001);
    cyc();
    bus.req_valid = '0;
    end_tile();
    bus.drain_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    bus.drain_ready = 1'b0;
    #1;
    total++;
    if (bus.drain_entry !== 3'd3 || bus.drain_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: entry=%0d valid=%b want 3 1", bus.drain_entry, bus.drain_valid);
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_drain");
    cyc();
    reset_n = 1'b1;
    cyc();
    start_tile(2'd2);
    for (int i = 0; i < 4; i++) set_lane(i, 8'd0, 16'h0000);
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL ptr_reset: req_ready=%b want 0001", bus.req_ready);
    end
    cyc();
    bus.req_valid = '0;
    end_tile();
    exp_q = '{16'h0, 16'h0};
    run_drain(2, 1'b0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_row = '0;
    bus.req_data = '0;
    bus.drain_ready = 1'b0;
    test_reset();
    test_fairness();
    test_accumulate();
    test_saturation();
    test_back_to_back_backpressure();
    test_illegal_start();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
